// File: rtl/netdma_mm2st_burst_adapter.sv
// netdma_mm2st_burst_adapter
//   Turns a byte-length read command into Avalon-MM burst reads and replays
//   the returned words as an Avalon-ST packet (sop/eop/empty generated here).
//   Requests are credit-gated against free FIFO space, so every word that has
//   been requested already has a FIFO slot reserved and the FIFO cannot
//   overflow.
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   cmd_*                      command: start byte address, byte length
//   abort_i                    abort current transfer (ignored in IDLE)
//   mm_*                       Avalon-MM burst read master
//   src_*                      Avalon-ST source, zero ready latency
//   busy_o, done_o, aborted_o  status; done/aborted are one-cycle pulses
module netdma_mm2st_burst_adapter #(
  parameter int DATA_WIDTH           = 64,
  parameter int FIFO_DEPTH           = 64,
  parameter int MAX_BURST            = 8,
  parameter int LEN_WIDTH            = 16,
  parameter int WORD_ADDRESSING      = 1,
  parameter int BYTES_REORDER_ENABLE = 0,
  localparam int NUM_BYTES = DATA_WIDTH / 8,
  localparam int EW        = $clog2(NUM_BYTES),
  localparam int BCW       = $clog2(MAX_BURST) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [31:0]           cmd_address_i,
  input  logic [LEN_WIDTH-1:0]  cmd_length_i,
  input  logic                  abort_i,
  output logic [31:0]           mm_address_o,
  output logic                  mm_read_o,
  output logic [BCW-1:0]        mm_burstcount_o,
  input  logic                  mm_waitrequest_i,
  input  logic [DATA_WIDTH-1:0] mm_readdata_i,
  input  logic                  mm_readdatavalid_i,
  output logic [DATA_WIDTH-1:0] src_data_o,
  output logic                  src_valid_o,
  input  logic                  src_ready_i,
  output logic                  src_sop_o,
  output logic                  src_eop_o,
  output logic [EW-1:0]         src_empty_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;  // holds 0..FIFO_DEPTH
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FLUSH} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [EW-1:0]         empty;
  } beat_t;

  state_t               state, state_nx;
  logic [31:0]          addr;
  logic [LEN_WIDTH-1:0] words_left, total_words, rx_cnt;
  logic [EW-1:0]        last_empty;
  logic [CW-1:0]        outstanding, fifo_used;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  beat_t                mem [FIFO_DEPTH];
  beat_t                wr_beat, head;
  logic [BCW-1:0]       bc;
  logic [CW:0]          credit;
  logic [LEN_WIDTH:0]   len_rnd;
  logic [EW-1:0]        len_lo;
  logic                 cmd_acc, req_acc, fifo_wr, fifo_rd, rdv_dec;

  assign len_rnd = {1'b0, cmd_length_i} + (LEN_WIDTH+1)'(NUM_BYTES - 1);
  assign len_lo  = cmd_length_i[EW-1:0];

  assign bc = (words_left > LEN_WIDTH'(MAX_BURST)) ? BCW'(MAX_BURST) : BCW'(words_left);
  // Slots already claimed = buffered words + words requested but not returned.
  assign credit = (CW+1)'(FIFO_DEPTH) - {1'b0, fifo_used} - {1'b0, outstanding};

  assign cmd_ready_o     = (state == S_IDLE);
  assign busy_o          = (state != S_IDLE);
  assign cmd_acc         = cmd_valid_i & cmd_ready_o;
  // Credit never shrinks while a request waits (a returned beat moves one
  // word from outstanding to fifo_used), so address/burstcount hold stable.
  assign mm_read_o       = (state == S_REQ) && (credit >= (CW+1)'(bc));
  assign mm_burstcount_o = bc;
  assign mm_address_o    = (WORD_ADDRESSING != 0) ? (addr >> EW) : addr;
  assign req_acc         = mm_read_o & ~mm_waitrequest_i;
  assign rdv_dec         = mm_readdatavalid_i & (outstanding != '0);
  // Beats returning during FLUSH are dropped on the floor.
  assign fifo_wr         = mm_readdatavalid_i & ((state == S_REQ) | (state == S_WAIT));

  assign head        = mem[rd_ptr];
  assign src_valid_o = (fifo_used != '0) && (state != S_FLUSH);
  assign fifo_rd     = src_valid_o & src_ready_i;
  assign src_sop_o   = src_valid_o & head.sop;
  assign src_eop_o   = src_valid_o & head.eop;
  assign src_empty_o = src_valid_o ? head.empty : '0;

  for (genvar b = 0; b < NUM_BYTES; b++) begin : g_byte
    if (BYTES_REORDER_ENABLE != 0) begin : g_rev
      assign src_data_o[b*8 +: 8] = src_valid_o ? head.data[(NUM_BYTES-1-b)*8 +: 8] : 8'h00;
    end else begin : g_fwd
      assign src_data_o[b*8 +: 8] = src_valid_o ? head.data[b*8 +: 8] : 8'h00;
    end
  end

  always_comb begin
    wr_beat.data  = mm_readdata_i;
    wr_beat.sop   = (rx_cnt == '0);
    wr_beat.eop   = ((rx_cnt + LEN_WIDTH'(1)) == total_words);
    wr_beat.empty = wr_beat.eop ? last_empty : '0;
  end

  always_comb begin
    state_nx  = state;
    done_o    = 1'b0;
    aborted_o = 1'b0;
    case (state)
      S_IDLE:  if (cmd_valid_i) state_nx = S_REQ;
      S_REQ: begin
        if (abort_i)                                        state_nx = S_FLUSH;
        else if (req_acc && (words_left == LEN_WIDTH'(bc))) state_nx = S_WAIT;
      end
      S_WAIT: begin
        // eop pop beats a coincident abort
        if (fifo_rd && head.eop) begin
          done_o   = 1'b1;
          state_nx = S_IDLE;
        end else if (abort_i) begin
          state_nx = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (outstanding == '0) begin
          aborted_o = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      addr        <= '0;
      words_left  <= '0;
      total_words <= '0;
      last_empty  <= '0;
      rx_cnt      <= '0;
      outstanding <= '0;
      fifo_used   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state       <= state_nx;
      outstanding <= outstanding + (req_acc ? CW'(bc) : CW'(0)) - (rdv_dec ? CW'(1) : CW'(0));
      if (cmd_acc) begin
        addr        <= cmd_address_i & ~32'(NUM_BYTES - 1);
        words_left  <= LEN_WIDTH'(len_rnd >> EW);
        total_words <= LEN_WIDTH'(len_rnd >> EW);
        last_empty  <= EW'(0) - len_lo;
        rx_cnt      <= '0;
      end else begin
        if (req_acc) begin
          addr       <= addr + (32'(bc) << EW);
          words_left <= words_left - LEN_WIDTH'(bc);
        end
        if (fifo_wr) rx_cnt <= rx_cnt + LEN_WIDTH'(1);
      end
      if (state == S_FLUSH) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        fifo_used <= '0;
      end else begin
        if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
        if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
        fifo_used <= fifo_used + (fifo_wr ? CW'(1) : CW'(0)) - (fifo_rd ? CW'(1) : CW'(0));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_wr) mem[wr_ptr] <= wr_beat;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && fifo_wr) assert (fifo_used != CW'(FIFO_DEPTH));
  end
endmodule

// File: tb/tb_netdma_mm2st_burst_adapter.sv
// Directed bench: 64-bit data, 16-word FIFO, max burst 8, word addressing.
// A slave model returns word data {~waddr, waddr}, one beat per cycle.
module tb_netdma_mm2st_burst_adapter;
  localparam int DW = 64;
  localparam int FD = 16;
  localparam int MB = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [31:0]   cmd_address = '0;
  logic [LW-1:0] cmd_length = '0;
  logic          abort = 1'b0;
  logic [31:0]   mm_address;
  logic          mm_read;
  logic [3:0]    mm_burstcount;
  logic          mm_waitrequest = 1'b0;
  logic [DW-1:0] mm_readdata = '0;
  logic          mm_readdatavalid = 1'b0;
  logic [DW-1:0] src_data;
  logic          src_valid, src_ready = 1'b1, src_sop, src_eop;
  logic [2:0]    src_empty;
  logic          busy, done, aborted;

  always #5 clk = ~clk;

  netdma_mm2st_burst_adapter #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .MAX_BURST(MB), .LEN_WIDTH(LW),
    .WORD_ADDRESSING(1), .BYTES_REORDER_ENABLE(0)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_address_i(cmd_address), .cmd_length_i(cmd_length),
    .abort_i(abort),
    .mm_address_o(mm_address), .mm_read_o(mm_read), .mm_burstcount_o(mm_burstcount),
    .mm_waitrequest_i(mm_waitrequest), .mm_readdata_i(mm_readdata),
    .mm_readdatavalid_i(mm_readdatavalid),
    .src_data_o(src_data), .src_valid_o(src_valid), .src_ready_i(src_ready),
    .src_sop_o(src_sop), .src_eop_o(src_eop), .src_empty_o(src_empty),
    .busy_o(busy), .done_o(done), .aborted_o(aborted)
  );

  int n_chk = 0, n_fail = 0;

  // slave + sink bookkeeping
  logic [31:0] pend[$];
  logic [31:0] acc_addr[$];
  int          acc_bc[$];
  logic [63:0] rx_data[$];
  logic        rx_sop[$], rx_eop[$];
  logic [2:0]  rx_empty[$];
  int          done_cnt = 0, abort_cnt = 0, valid_cnt = 0;
  int          hold_left = 0, hold_cnt = 0;
  logic        rdv_en = 1'b1, held = 1'b0, stab_bad = 1'b0;
  logic [31:0] h_addr, w;
  logic [3:0]  h_bc;

  // Slave: data return (min latency 1 cycle), then waitrequest/accept.
  always @(negedge clk) begin
    if (rdv_en && pend.size() > 0) begin
      w = pend.pop_front();
      mm_readdatavalid = 1'b1;
      mm_readdata = {~w, w};
    end else begin
      mm_readdatavalid = 1'b0;
      mm_readdata = '0;
    end
    if (mm_read) begin
      if (held && (mm_address !== h_addr || mm_burstcount !== h_bc)) stab_bad = 1'b1;
      if (hold_left > 0) begin
        mm_waitrequest = 1'b1;
        hold_left--;
        hold_cnt++;
        held = 1'b1;
        h_addr = mm_address;
        h_bc = mm_burstcount;
      end else begin
        mm_waitrequest = 1'b0;
        held = 1'b0;
        acc_addr.push_back(mm_address);
        acc_bc.push_back(int'(mm_burstcount));
        for (int i = 0; i < int'(mm_burstcount); i++) pend.push_back(mm_address + 32'(i));
      end
    end else begin
      mm_waitrequest = 1'b0;
      held = 1'b0;
    end
  end

  // Sink monitor
  always @(negedge clk) begin
    if (src_valid) valid_cnt++;
    if (src_valid && src_ready) begin
      rx_data.push_back(src_data);
      rx_sop.push_back(src_sop);
      rx_eop.push_back(src_eop);
      rx_empty.push_back(src_empty);
    end
    if (done) done_cnt++;
    if (aborted) abort_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [LW-1:0] l);
    acc_addr.delete(); acc_bc.delete();
    rx_data.delete(); rx_sop.delete(); rx_eop.delete(); rx_empty.delete();
    valid_cnt = 0;
    cmd_address = a;
    cmd_length  = l;
    cmd_valid   = 1'b1;
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
  endtask

  task automatic wait_evt(input string tag, input int bd, input int ba);
    int k = 0;
    while (done_cnt == bd && abort_cnt == ba && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, " timeout"}, 64'(k < 2000), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag, input logic [31:0] base, input int n, input logic [2:0] emp);
    logic [31:0] ew;
    check({tag, " beats"}, 64'(rx_data.size()), 64'(n));
    for (int i = 0; i < n && i < rx_data.size(); i++) begin
      ew = base + 32'(i);
      check($sformatf("%s data%0d", tag, i), rx_data[i], {~ew, ew});
      check($sformatf("%s sop%0d", tag, i), 64'(rx_sop[i]), 64'(i == 0));
      check($sformatf("%s eop%0d", tag, i), 64'(rx_eop[i]), 64'(i == n - 1));
      check($sformatf("%s empty%0d", tag, i), 64'(rx_empty[i]), (i == n - 1) ? 64'(emp) : 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    // reset state
    check("rst cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst mm_read", 64'(mm_read), 64'd0);
    check("rst mm_address", 64'(mm_address), 64'd0);
    check("rst burstcount", 64'(mm_burstcount), 64'd0);
    check("rst src_valid", 64'(src_valid), 64'd0);
    check("rst src_data", src_data, 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst aborted", 64'(aborted), 64'd0);
    rst = 1'b0;
    idle(2);

    // T1: addr 0x1000, len 20 -> 3 words, empty 4
    start(32'h1000, 16'd20);
    wait_evt("t1", 0, 0);
    idle(3);
    check("t1 done_cnt", 64'(done_cnt), 64'd1);
    check("t1 n_req", 64'(acc_addr.size()), 64'd1);
    check("t1 addr", 64'(acc_addr[0]), 64'h200);
    check("t1 bc", 64'(acc_bc[0]), 64'd3);
    check_stream("t1", 32'h200, 3, 3'd4);
    check("t1 busy", 64'(busy), 64'd0);
    check("t1 cmd_ready", 64'(cmd_ready), 64'd1);

    // T2: len 100 -> 13 words as bursts 8 + 5
    start(32'h1000, 16'd100);
    wait_evt("t2", 1, 0);
    idle(3);
    check("t2 n_req", 64'(acc_addr.size()), 64'd2);
    check("t2 addr0", 64'(acc_addr[0]), 64'h200);
    check("t2 bc0", 64'(acc_bc[0]), 64'd8);
    check("t2 addr1", 64'(acc_addr[1]), 64'h208);
    check("t2 bc1", 64'(acc_bc[1]), 64'd5);
    check_stream("t2", 32'h200, 13, 3'd4);
    check("t2 done_cnt", 64'(done_cnt), 64'd2);

    // T3: sink stalled, requests limited by 16-word credit
    src_ready = 1'b0;
    start(32'h0, 16'd256);
    idle(60);
    check("t3 stalled n_req", 64'(acc_addr.size()), 64'd2);
    check("t3 stalled src_valid", 64'(src_valid), 64'd1);
    check("t3 stalled busy", 64'(busy), 64'd1);
    check("t3 stalled done", 64'(done_cnt), 64'd2);
    src_ready = 1'b1;
    wait_evt("t3", 2, 0);
    idle(3);
    check("t3 n_req", 64'(acc_addr.size()), 64'd4);
    check("t3 addr3", 64'(acc_addr[3]), 64'h18);
    check_stream("t3", 32'h0, 32, 3'd0);
    check("t3 done_cnt", 64'(done_cnt), 64'd3);

    // T4: waitrequest held 5 cycles on the first request
    hold_cnt = 0;
    stab_bad = 1'b0;
    hold_left = 5;
    start(32'h40, 16'd16);
    wait_evt("t4", 3, 0);
    idle(3);
    check("t4 held cycles", 64'(hold_cnt), 64'd5);
    check("t4 stable", 64'(stab_bad), 64'd0);
    check("t4 n_req", 64'(acc_addr.size()), 64'd1);
    check("t4 addr", 64'(acc_addr[0]), 64'h8);
    check("t4 bc", 64'(acc_bc[0]), 64'd2);
    check_stream("t4", 32'h8, 2, 3'd0);

    // T5: single word, sop and eop together
    start(32'h2000, 16'd8);
    wait_evt("t5", 4, 0);
    idle(3);
    check("t5 bc", 64'(acc_bc[0]), 64'd1);
    check("t5 addr", 64'(acc_addr[0]), 64'h400);
    check_stream("t5", 32'h400, 1, 3'd0);
    check("t5 done_cnt", 64'(done_cnt), 64'd5);

    // T6: abort in REQ with 16 words outstanding and data held back
    rdv_en = 1'b0;
    start(32'h0, 16'd256);
    idle(10);
    check("t6 pre n_req", 64'(acc_addr.size()), 64'd2);
    check("t6 pre busy", 64'(busy), 64'd1);
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    rdv_en = 1'b1;
    wait_evt("t6", 5, 0);
    idle(5);
    check("t6 abort_cnt", 64'(abort_cnt), 64'd1);
    check("t6 done_cnt", 64'(done_cnt), 64'd5);
    check("t6 n_req", 64'(acc_addr.size()), 64'd2);
    check("t6 beats", 64'(rx_data.size()), 64'd0);
    check("t6 valid seen", 64'(valid_cnt), 64'd0);
    check("t6 cmd_ready", 64'(cmd_ready), 64'd1);
    check("t6 busy", 64'(busy), 64'd0);

    // T7: abort in IDLE is ignored
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    idle(3);
    check("t7 abort_cnt", 64'(abort_cnt), 64'd1);
    check("t7 busy", 64'(busy), 64'd0);

    // T8: clean transfer after abort
    start(32'h1000, 16'd20);
    wait_evt("t8", 5, 1);
    idle(3);
    check_stream("t8", 32'h200, 3, 3'd4);
    check("t8 done_cnt", 64'(done_cnt), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/netdma_mm2st_burst_adapter.md
Name: netdma_mm2st_burst_adapter

Overview:
Burst-capable, credit-controlled successor to the netdma read-side MM-to-stream adapter. Accepts a byte-length read command, splits it into Avalon-MM burst reads, and tracks in-flight words against internal FIFO space so read data can never overflow. It generates sop/eop/empty internally from the command length and drives a streaming source. Sits in the netdma readmaster between the descriptor engine and the stream output.

Parameters:
DATA_WIDTH, 64, data bus width in bits; power of two, >= 16.
FIFO_DEPTH, 64, data FIFO depth in words; power of two, >= 2*MAX_BURST.
MAX_BURST, 8, maximum burstcount per request; power of two, >= 1.
LEN_WIDTH, 16, width of the command byte-length field.
WORD_ADDRESSING, 1, 1: mm_address_o is a word address (byte address >> log2(NUM_BYTES)); 0: byte address.
BYTES_REORDER_ENABLE, 0, 1: reverse byte order of src_data_o.

Ports:
clk_i  in  1  clock; all logic on its rising edge.
rst_i  in  1  synchronous active-high reset.
cmd_valid_i  in  1  command valid.
cmd_ready_o  out  1  command accepted when valid&ready.
cmd_address_i  in  32  start byte address; low log2(NUM_BYTES) bits ignored (word-aligned).
cmd_length_i  in  LEN_WIDTH  transfer length in bytes; 0 is illegal.
abort_i  in  1  abort the current transfer.
mm_address_o  out  32  read address.
mm_read_o  out  1  read request.
mm_burstcount_o  out  log2(MAX_BURST)+1  burst length in words.
mm_waitrequest_i  in  1  slave stall.
mm_readdata_i  in  DATA_WIDTH  read data.
mm_readdatavalid_i  in  1  read data valid.
src_data_o  out  DATA_WIDTH  stream data.
src_valid_o  out  1  stream valid.
src_ready_i  in  1  stream ready; zero ready latency.
src_sop_o  out  1  start of packet.
src_eop_o  out  1  end of packet.
src_empty_o  out  log2(NUM_BYTES)  empty bytes on eop beat.
busy_o  out  1  high while not IDLE.
done_o  out  1  one-cycle pulse when the eop beat is accepted by the sink.
aborted_o  out  1  one-cycle pulse on abort completion.

Behaviour:
- NUM_BYTES = DATA_WIDTH/8; total_words = ceil(len/NUM_BYTES); last_empty = total_words*NUM_BYTES - len.
- Reset: state IDLE; all counters and FIFO cleared; every output 0 except cmd_ready_o = 1.
- IDLE: cmd_ready_o = 1. On accept, latch address, total_words and last_empty, then go to REQ. cmd_ready_o is 0 in all other states.
- REQ: bc = min(req_words_left, MAX_BURST). Credit = FIFO_DEPTH - fifo_used - outstanding.
  - mm_read_o is asserted only if credit >= bc. While asserted, address and burstcount hold stable through waitrequest.
  - Request accept = read & ~waitrequest. On accept: outstanding += bc; address += bc*NUM_BYTES bytes; req_words_left -= bc.
  - Go to WAIT after the final burst is accepted.
  - Back-to-back requests are allowed (next request on the cycle after accept).
- Each readdatavalid: outstanding -= 1. The beat is written to the FIFO with sop = (first beat of the transfer), eop = (rx beat count == total_words), and empty = last_empty on the eop beat, 0 otherwise.
- An accept and a readdatavalid in the same cycle apply both: outstanding += bc - 1.
- Stream side: src_valid_o = ~fifo_empty; pop on valid & ready. Data, sop, eop and empty come from the FIFO head (showahead).
- WAIT: go to IDLE with a done_o pulse on the cycle the eop beat is popped.
- Single-word transfer: sop and eop are asserted on the same beat.
- Abort (REQ or WAIT): no new requests are issued from the next cycle. A request held under waitrequest is dropped (read deasserted). State goes to FLUSH.
- FLUSH: incoming readdata is discarded and the FIFO is flushed; src_valid_o = 0. When outstanding == 0, go to IDLE with an aborted_o pulse and no done_o.
- abort_i in IDLE is ignored. abort_i in the same cycle as the eop pop: done wins and abort is ignored.
- Invariant: fifo_used + outstanding <= FIFO_DEPTH at all times. The FIFO never overflows; a write when full is an assertion failure.
- Counters are sized for FIFO_DEPTH with no wrap. The address wraps modulo 2^32.
- rst_i mid-transfer returns to reset state on the next edge. Data still in flight from the slave afterwards is the system's responsibility.

Test Plan:
- DATA_WIDTH=64, cmd addr 0x1000, len 20 -> one burst: burstcount 3, address 0x200 (word). Three beats: sop on beat 0, eop on beat 2, empty 4, done_o pulse.
- len 100, MAX_BURST 8 -> 13 words as bursts 8 and 5. Word addresses 0x200 and 0x208. Stream of 13 beats, empty 4.
- FIFO_DEPTH 16, len 256, src_ready_i held 0 -> requests stop once 16 words are buffered or outstanding. Then release ready: all 32 beats are delivered in order with no overflow.
- waitrequest held 5 cycles on the first request -> address and burstcount are stable throughout. Exactly 1 accept is counted.
- len 8 (single word) -> burstcount 1; one beat with sop=eop=1, empty 0.
- Abort in REQ with 2 bursts (16 words) outstanding, data still returning -> no further reads. The 16 beats are discarded, src_valid_o stays 0, then aborted_o pulses and cmd_ready_o returns to 1.
